// File: rtl/status_tag_vector_if.sv
// Bundles the status_tag_vector command inputs and its status outputs.
// Latency: none; this interface is wiring only.
// Backpressure: none; a push into a full vector is dropped and flagged by the block.
interface status_tag_vector_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr_i;
    logic             push_i;
    logic [WIDTH-1:0] push_value_i;
    logic [TAG_W-1:0] push_tag_i;
    logic             pull_i;
    logic             set_i;
    logic [TAG_W-1:0] set_tag_i;
    logic [WIDTH-1:0] set_value_i;

    logic [WIDTH-1:0] value_o;
    logic [TAG_W-1:0] tag_o;
    logic             valid_o;
    logic             full_o;
    logic             afull_o;
    logic [CW-1:0]    count_o;
    logic             set_hit_o;
    logic             set_miss_o;
    logic             ovf_o;
    logic             udf_o;

    // Command source side.
    modport master (
        output clr_i, push_i, push_value_i, push_tag_i, pull_i,
               set_i, set_tag_i, set_value_i,
        input  value_o, tag_o, valid_o, full_o, afull_o, count_o,
               set_hit_o, set_miss_o, ovf_o, udf_o
    );

    // The vector itself.
    modport slave (
        input  clr_i, push_i, push_value_i, push_tag_i, pull_i,
               set_i, set_tag_i, set_value_i,
        output value_o, tag_o, valid_o, full_o, afull_o, count_o,
               set_hit_o, set_miss_o, ovf_o, udf_o
    );
endinterface

// File: rtl/status_tag_vector.sv
// Age-ordered tagged vector: push at the tail, pull from the head, set values by tag.
// Latency: every operation is visible on the registered outputs one cycle later.
// Backpressure: none; a push when full is dropped (ovf_o), a pull when empty is ignored (udf_o).
module status_tag_vector #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int TAG_W    = 4,
    parameter int AFULL_TH = DEPTH - 2
) (
    input logic                clk_i,
    input logic                rsn_i,
    status_tag_vector_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] val_q [DEPTH];
    logic [WIDTH-1:0] val_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             is_empty, is_full, do_pull, do_push, any_match;
    logic [DEPTH-1:0] match, set_sel;
    logic [CW-1:0]    wr_idx;

    // Next-state: clear, then shift on pull, apply tag set to survivors, write the push slot.
    always_comb begin
        val_d     = val_q;
        tag_d     = tag_q;
        vld_d     = vld_q;
        count_d   = count_q;
        full_d    = full_q;
        afull_d   = afull_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        is_empty  = 1'b0;
        is_full   = 1'b0;
        do_pull   = 1'b0;
        do_push   = 1'b0;
        any_match = 1'b0;
        match     = '0;
        set_sel   = '0;
        wr_idx    = '0;

        if (bus.clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_d[i] = '0;
                tag_d[i] = '0;
            end
            vld_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
            afull_d = 1'b0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            is_empty = (count_q == '0);
            is_full  = (count_q == CW'(DEPTH));
            do_pull  = bus.pull_i && !is_empty;
            // A pull frees a slot, so push+pull on a full vector still succeeds.
            do_push  = bus.push_i && (!is_full || do_pull);

            // Matches are judged against the contents at cycle start.
            for (int i = 0; i < DEPTH; i++) begin
                match[i]  = vld_q[i] && (tag_q[i] == bus.set_tag_i);
                any_match = any_match | match[i];
            end

            if (do_pull) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    val_d[i]   = val_q[i+1];
                    tag_d[i]   = tag_q[i+1];
                    vld_d[i]   = vld_q[i+1];
                    set_sel[i] = match[i+1];
                end
                val_d[DEPTH-1]   = '0;
                tag_d[DEPTH-1]   = '0;
                vld_d[DEPTH-1]   = 1'b0;
                set_sel[DEPTH-1] = 1'b0;
            end else begin
                set_sel = match;
            end

            // The pulled head has already shifted out, so it never takes the set value.
            if (bus.set_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (set_sel[i]) begin
                        val_d[i] = bus.set_value_i;
                    end
                end
            end

            // The push lands in an empty slot after any set, so it keeps its own value.
            if (do_push) begin
                wr_idx = do_pull ? (count_q - 1'b1) : count_q;
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        val_d[i] = bus.push_value_i;
                        tag_d[i] = bus.push_tag_i;
                        vld_d[i] = 1'b1;
                    end
                end
            end

            count_d = count_q + CW'(do_push) - CW'(do_pull);
            full_d  = (count_d == CW'(DEPTH));
            afull_d = (count_d >= CW'(AFULL_TH));
            hit_d   = bus.set_i && any_match;
            miss_d  = bus.set_i && !any_match;
            if (bus.push_i && is_full && !bus.pull_i) begin
                ovf_d = 1'b1;
            end
            if (bus.pull_i && is_empty) begin
                udf_d = 1'b1;
            end
        end
    end

    // State registers; reset empties the vector and drops all flags.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            val_q   <= val_d;
            tag_q   <= tag_d;
            vld_q   <= vld_d;
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs come straight from flops; the head slot is zeroed whenever the vector is empty.
    assign bus.value_o    = val_q[0];
    assign bus.tag_o      = tag_q[0];
    assign bus.valid_o    = vld_q[0];
    assign bus.count_o    = count_q;
    assign bus.full_o     = full_q;
    assign bus.afull_o    = afull_q;
    assign bus.set_hit_o  = hit_q;
    assign bus.set_miss_o = miss_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.udf_o      = udf_q;

endmodule

// File: tb/tb_status_tag_vector.sv
// Directed bench for status_tag_vector at DEPTH=4, WIDTH=8, TAG_W=4, AFULL_TH=3.
// Latency: inputs change 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: exercised through overflow, underflow and push+pull on full/empty.
module tb_status_tag_vector;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    logic clk_i = 1'b0;
    logic rsn_i = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    status_tag_vector_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    status_tag_vector #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W), .AFULL_TH(3)
    ) dut (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.clr_i        = 1'b0;
        bus.push_i       = 1'b0;
        bus.push_value_i = '0;
        bus.push_tag_i   = '0;
        bus.pull_i       = 1'b0;
        bus.set_i        = 1'b0;
        bus.set_tag_i    = '0;
        bus.set_value_i  = '0;
    endtask

    // One clock with the given command, then inputs return to idle.
    task automatic op(input logic push, input logic [7:0] pv, input logic [3:0] pt,
                      input logic pull, input logic set, input logic [3:0] st,
                      input logic [7:0] sv);
        bus.push_i       = push;
        bus.push_value_i = pv;
        bus.push_tag_i   = pt;
        bus.pull_i       = pull;
        bus.set_i        = set;
        bus.set_tag_i    = st;
        bus.set_value_i  = sv;
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic check_all_zero(input string ctx);
        chk({ctx, ".value"}, 32'(bus.value_o), 32'h0);
        chk({ctx, ".tag"},   32'(bus.tag_o),   32'h0);
        chk({ctx, ".valid"}, 32'(bus.valid_o), 32'h0);
        chk({ctx, ".count"}, 32'(bus.count_o), 32'h0);
        chk({ctx, ".full"},  32'(bus.full_o),  32'h0);
        chk({ctx, ".afull"}, 32'(bus.afull_o), 32'h0);
        chk({ctx, ".hit"},   32'(bus.set_hit_o),  32'h0);
        chk({ctx, ".miss"},  32'(bus.set_miss_o), 32'h0);
        chk({ctx, ".ovf"},   32'(bus.ovf_o), 32'h0);
        chk({ctx, ".udf"},   32'(bus.udf_o), 32'h0);
    endtask

    initial begin
        idle_inputs();
        #12;
        check_all_zero("reset");
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;

        // Fill three entries; the first one appears on the head one cycle later.
        op(1'b1, 8'h11, 4'd1, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("first_push.valid", 32'(bus.valid_o), 32'h1);
        chk("first_push.value", 32'(bus.value_o), 32'h11);
        chk("first_push.count", 32'(bus.count_o), 32'h1);
        op(1'b1, 8'h22, 4'd2, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("two.afull", 32'(bus.afull_o), 32'h0);
        op(1'b1, 8'h33, 4'd3, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("three.value", 32'(bus.value_o), 32'h11);
        chk("three.tag",   32'(bus.tag_o),   32'h1);
        chk("three.count", 32'(bus.count_o), 32'h3);
        chk("three.afull", 32'(bus.afull_o), 32'h1);
        chk("three.full",  32'(bus.full_o),  32'h0);

        // Fill, then overflow.
        op(1'b1, 8'h44, 4'd4, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("four.full", 32'(bus.full_o), 32'h1);
        chk("four.ovf",  32'(bus.ovf_o),  32'h0);
        op(1'b1, 8'h55, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("ovf.full",  32'(bus.full_o),  32'h1);
        chk("ovf.ovf",   32'(bus.ovf_o),   32'h1);
        chk("ovf.count", 32'(bus.count_o), 32'h4);
        chk("ovf.value", 32'(bus.value_o), 32'h11);

        // Push+pull while full: 11 leaves, 66 joins at the tail.
        op(1'b1, 8'h66, 4'd6, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("pp_full.value", 32'(bus.value_o), 32'h22);
        chk("pp_full.tag",   32'(bus.tag_o),   32'h2);
        chk("pp_full.count", 32'(bus.count_o), 32'h4);
        chk("pp_full.ovf",   32'(bus.ovf_o),   32'h1);

        // Drain: 33, 44, 66 in order; the dropped 55 never appears.
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("drain1.value", 32'(bus.value_o), 32'h33);
        chk("drain1.full",  32'(bus.full_o),  32'h0);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("drain2.value", 32'(bus.value_o), 32'h44);
        chk("drain2.afull", 32'(bus.afull_o), 32'h0);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("drain3.value", 32'(bus.value_o), 32'h66);
        chk("drain3.tag",   32'(bus.tag_o),   32'h6);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("empty.value", 32'(bus.value_o), 32'h0);
        chk("empty.valid", 32'(bus.valid_o), 32'h0);
        chk("empty.count", 32'(bus.count_o), 32'h0);
        chk("empty.udf",   32'(bus.udf_o),   32'h0);

        // Flush the sticky overflow, then load tags {2,5,2}.
        bus.clr_i = 1'b1;
        op(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("clr.ovf", 32'(bus.ovf_o), 32'h0);
        op(1'b1, 8'h10, 4'd2, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b1, 8'h20, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b1, 8'h30, 4'd2, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("set_pre.hit", 32'(bus.set_hit_o), 32'h0);

        // Set tag 2 with a same-cycle pull: head (10,2) leaves untouched, (30,2) becomes AA.
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 4'd2, 8'hAA);
        chk("set.hit",   32'(bus.set_hit_o),  32'h1);
        chk("set.miss",  32'(bus.set_miss_o), 32'h0);
        chk("set.value", 32'(bus.value_o), 32'h20);
        chk("set.tag",   32'(bus.tag_o),   32'h5);
        chk("set.count", 32'(bus.count_o), 32'h2);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("set_pulse.hit", 32'(bus.set_hit_o), 32'h0);
        chk("set_surv.value", 32'(bus.value_o), 32'hAA);
        chk("set_surv.tag",   32'(bus.tag_o),   32'h2);

        op(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 4'd9, 8'hEE);
        chk("miss.miss",  32'(bus.set_miss_o), 32'h1);
        chk("miss.hit",   32'(bus.set_hit_o),  32'h0);
        chk("miss.value", 32'(bus.value_o),    32'hAA);

        // Same-cycle push of a matching tag keeps its own value.
        op(1'b1, 8'h77, 4'd2, 1'b0, 1'b1, 4'd2, 8'hBB);
        chk("setpush.value", 32'(bus.value_o), 32'hBB);
        chk("setpush.count", 32'(bus.count_o), 32'h2);
        chk("setpush.miss",  32'(bus.set_miss_o), 32'h0);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("setpush_new.value", 32'(bus.value_o), 32'h77);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("drain_b.count", 32'(bus.count_o), 32'h0);

        // Push+pull on empty: push lands, pull flagged as underflow.
        op(1'b1, 8'h12, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("pp_empty.count", 32'(bus.count_o), 32'h1);
        chk("pp_empty.udf",   32'(bus.udf_o),   32'h1);
        chk("pp_empty.value", 32'(bus.value_o), 32'h12);
        chk("pp_empty.valid", 32'(bus.valid_o), 32'h1);

        // Clear wins over a simultaneous push and set.
        bus.clr_i = 1'b1;
        op(1'b1, 8'h13, 4'd1, 1'b0, 1'b1, 4'd1, 8'hCC);
        check_all_zero("clr");

        // Asynchronous reset mid-stream.
        op(1'b1, 8'h21, 4'd7, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b1, 8'h22, 4'd8, 1'b0, 1'b0, 4'd0, 8'h00);
        op(1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00);
        chk("prereset.value", 32'(bus.value_o), 32'h22);
        #2;
        rsn_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        op(1'b1, 8'h99, 4'd3, 1'b0, 1'b0, 4'd0, 8'h00);
        chk("post_rst.value", 32'(bus.value_o), 32'h99);
        chk("post_rst.tag",   32'(bus.tag_o),   32'h3);
        chk("post_rst.count", 32'(bus.count_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
